// File: rtl/countdown_session_ctrl.sv
// Session controller for the countdown timer: sequences load/run/pause,
// completion and timeout retries, and presents status for display/game logic.
module countdown_session_ctrl #(
  parameter int DEFAULT_SEC = 10,
  parameter int RETRY_MAX   = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_start,
  input  logic       i_pause,
  input  logic       i_done,
  input  logic       i_abort,
  input  logic [3:0] sw,
  input  logic       i_timeout,
  input  logic [3:0] i_time_val,
  output logic       o_start_timer,
  output logic       o_en,
  output logic [3:0] o_load_val,
  output logic [2:0] o_state,
  output logic [3:0] o_attempt,
  output logic       o_success,
  output logic       o_expired,
  output logic [3:0] o_rem_sec
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_RUN     = 3'd2,
    S_PAUSE   = 3'd3,
    S_DONE    = 3'd4,
    S_EXPIRED = 3'd5
  } state_t;

  localparam logic [3:0] DEF_DUR   = 4'(DEFAULT_SEC);
  localparam logic [3:0] RETRY_LIM = 4'(RETRY_MAX);

  state_t     state;
  logic       start_prev;
  logic       pause_prev;
  logic       start_evt;
  logic       pause_evt;
  logic [3:0] dur;
  logic [3:0] rem_latch;
  logic [3:0] sel_dur;

  assign start_evt = i_start & ~start_prev;
  assign pause_evt = i_pause & ~pause_prev;
  assign sel_dur   = (sw == 4'd0) ? DEF_DUR : sw;

  assign o_state    = state;
  assign o_load_val = dur;

  // History resets to 1 so a button held through reset must be re-pressed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      start_prev    <= 1'b1;
      pause_prev    <= 1'b1;
      dur           <= 4'd0;
      rem_latch     <= 4'd0;
      o_start_timer <= 1'b0;
      o_en          <= 1'b0;
      o_attempt     <= 4'd0;
      o_success     <= 1'b0;
      o_expired     <= 1'b0;
    end else begin
      start_prev    <= i_start;
      pause_prev    <= i_pause;
      o_start_timer <= 1'b0;
      o_success     <= 1'b0;
      case (state)
        S_IDLE: begin
          o_en <= 1'b0;
          if (start_evt) begin
            state         <= S_LOAD;
            o_start_timer <= 1'b1;
            o_attempt     <= 4'd1;
            o_expired     <= 1'b0;
            dur           <= sel_dur;
          end
        end
        S_LOAD: begin
          if (i_abort) begin
            state     <= S_IDLE;
            o_en      <= 1'b0;
            o_attempt <= 4'd0;
          end else begin
            state <= S_RUN;
            o_en  <= 1'b1;
          end
        end
        S_RUN: begin
          // Abort beats done beats timeout beats pause; the user wins a done/timeout tie.
          if (i_abort) begin
            state     <= S_IDLE;
            o_en      <= 1'b0;
            o_attempt <= 4'd0;
          end else if (i_done) begin
            state     <= S_DONE;
            o_en      <= 1'b0;
            o_success <= 1'b1;
            rem_latch <= i_time_val;
          end else if (i_timeout) begin
            o_en <= 1'b0;
            if (o_attempt < RETRY_LIM) begin
              state         <= S_LOAD;
              o_start_timer <= 1'b1;
              o_attempt     <= o_attempt + 4'd1;
            end else begin
              state     <= S_EXPIRED;
              o_expired <= 1'b1;
            end
          end else if (pause_evt) begin
            state <= S_PAUSE;
            o_en  <= 1'b0;
          end
        end
        S_PAUSE: begin
          if (i_abort) begin
            state     <= S_IDLE;
            o_en      <= 1'b0;
            o_attempt <= 4'd0;
          end else if (pause_evt) begin
            state <= S_RUN;
            o_en  <= 1'b1;
          end
        end
        S_DONE, S_EXPIRED: begin
          o_en <= 1'b0;
          if (i_abort) begin
            state     <= S_IDLE;
            o_attempt <= 4'd0;
            o_expired <= 1'b0;
          end else if (start_evt) begin
            state         <= S_LOAD;
            o_start_timer <= 1'b1;
            o_attempt     <= 4'd1;
            o_expired     <= 1'b0;
            dur           <= sel_dur;
          end
        end
        default: begin
          state     <= S_IDLE;
          o_en      <= 1'b0;
          o_attempt <= 4'd0;
          o_expired <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    o_rem_sec = 4'd0;
    case (state)
      S_RUN, S_PAUSE: o_rem_sec = i_time_val;
      S_LOAD:         o_rem_sec = dur;
      S_DONE:         o_rem_sec = rem_latch;
      default:        o_rem_sec = 4'd0;
    endcase
  end

endmodule
